// File: rtl/rtc_pkg.sv
// rtc_pkg -- shared types and constants for the hours/minutes/seconds
// real-time clock (rtc_hms_counter and its prescaler).
//   state_t : run/stop control state
//   *_W     : binary widths of the time fields
//   *_MAX   : largest legal value of the seconds/minutes fields
package rtc_pkg;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(59);
  localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(59);

endpackage

// File: rtl/rtc_prescaler.sv
// rtc_prescaler -- divides clk down to a one-second tick.
// Counts 0..CLK_DIV-1 while enabled and holds its value while disabled, so a
// partially elapsed second survives a stop/resume.
//   clk   : system clock
//   reset : synchronous active-high reset, count -> 0
//   en    : count enable
//   clr   : synchronous clear to 0 (wins over en)
//   tick  : combinational, high in the cycle the count wraps (en && at max)
module rtc_prescaler #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = en && (count == CNT_MAX);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rtc_hms_counter.sv
// rtc_hms_counter -- binary hours/minutes/seconds real-time clock.
// Optional feature macro: RTC_ALARM_EN (adds the alarm ports and logic).
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   start                : level, 1 = run, 0 = hold
//   load, ld_sec/min/hour: one-cycle load strobe and the time to load
//   mode_12h             : selects 12-hour display on out_hour/out_pm
//   out_sec/min/hour/pm  : displayed time
//   sec_tick, day_wrap   : one-cycle pulses on a second advance / day rollover
//   load_err             : one-cycle pulse when a load is out of range
//   running              : 1 while in RUNNING
//   alarm_arm/min/hour, alarm_hit : alarm compare (RTC_ALARM_EN only)
module rtc_hms_counter
  import rtc_pkg::*;
#(
  parameter int CLK_DIV       = 50_000_000,
  parameter int HOURS_PER_DAY = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load,
  input  logic [SEC_W-1:0]  ld_sec,
  input  logic [MIN_W-1:0]  ld_min,
  input  logic [HOUR_W-1:0] ld_hour,
  input  logic              mode_12h,
`ifdef RTC_ALARM_EN
  input  logic              alarm_arm,
  input  logic [MIN_W-1:0]  alarm_min,
  input  logic [HOUR_W-1:0] alarm_hour,
  output logic              alarm_hit,
`endif
  output logic [SEC_W-1:0]  out_sec,
  output logic [MIN_W-1:0]  out_min,
  output logic [HOUR_W-1:0] out_hour,
  output logic              out_pm,
  output logic              sec_tick,
  output logic              day_wrap,
  output logic              load_err,
  output logic              running
);

  localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOURS_PER_DAY - 1);
  localparam logic [HOUR_W-1:0] HOUR_NOON = HOUR_W'(12);

  state_t state, state_next;

  logic [SEC_W-1:0]  sec, sec_next;
  logic [MIN_W-1:0]  min, min_next;
  logic [HOUR_W-1:0] hour, hour_next;
  logic              wrap_next;
  logic              tick;
  logic              load_ok;

  // ---------------- run/stop FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= STOPPED;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    state_next = state;
    case (state)
      STOPPED: if (start)  state_next = RUNNING;
      RUNNING: if (!start) state_next = STOPPED;
      default: state_next = STOPPED;
    endcase
  end

  always_comb begin
    running = (state == RUNNING);
  end

  // ---------------- prescaler ----------------
  assign load_ok = load && (ld_sec <= SEC_MAX) && (ld_min <= MIN_MAX)
                        && (ld_hour <= HOUR_LAST);

  // An accepted load restarts the second from zero.
  rtc_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (running),
    .clr   (load_ok),
    .tick  (tick)
  );

  // ---------------- time increment with full carry chain ----------------
  always_comb begin
    sec_next  = sec + SEC_W'(1);
    min_next  = min;
    hour_next = hour;
    wrap_next = 1'b0;
    if (sec == SEC_MAX) begin
      sec_next = '0;
      min_next = min + MIN_W'(1);
      if (min == MIN_MAX) begin
        min_next  = '0;
        hour_next = hour + HOUR_W'(1);
        if (hour == HOUR_LAST) begin
          hour_next = '0;
          wrap_next = 1'b1;
        end
      end
    end
  end

  // An accepted load overrides a coincident tick; a rejected load does not.
  always_ff @(posedge clk) begin
    if (reset) begin
      sec      <= '0;
      min      <= '0;
      hour     <= '0;
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
      load_err <= 1'b0;
    end else begin
      sec_tick <= tick && !load_ok;
      day_wrap <= tick && !load_ok && wrap_next;
      load_err <= load && !load_ok;
      if (load_ok) begin
        sec  <= ld_sec;
        min  <= ld_min;
        hour <= ld_hour;
      end else if (tick) begin
        sec  <= sec_next;
        min  <= min_next;
        hour <= hour_next;
      end
    end
  end

`ifdef RTC_ALARM_EN
  // Compare against the value about to be written, so the pulse lines up
  // with the edge on which the matching time appears.
  logic              time_upd;
  logic [MIN_W-1:0]  min_new;
  logic [HOUR_W-1:0] hour_new;
  logic              sec_new_zero;

  always_comb begin
    time_upd     = load_ok || tick;
    min_new      = load_ok ? ld_min  : min_next;
    hour_new     = load_ok ? ld_hour : hour_next;
    sec_new_zero = load_ok ? (ld_sec == '0) : (sec_next == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) alarm_hit <= 1'b0;
    else       alarm_hit <= alarm_arm && time_upd && sec_new_zero
                            && (min_new == alarm_min) && (hour_new == alarm_hour);
  end
`endif

  // ---------------- display mapping ----------------
  always_comb begin
    out_sec  = sec;
    out_min  = min;
    out_hour = hour;
    out_pm   = 1'b0;
    if (mode_12h) begin
      out_pm = (hour >= HOUR_NOON);
      if (hour == '0)            out_hour = HOUR_NOON;
      else if (hour > HOUR_NOON) out_hour = hour - HOUR_NOON;
    end
  end

endmodule

// File: tb/tb_rtc_hms_counter.sv
// tb_rtc_hms_counter -- self-checking bench for rtc_hms_counter (CLK_DIV=4).
// The reference model keeps time as seconds-of-day plus a prescaler phase and
// derives every expected output from that with plain arithmetic.
// Define RTC_ALARM_EN for both bench and RTL to cover the alarm.
module tb_rtc_hms_counter;

  localparam int CLK_DIV = 4;
  localparam int HPD     = 24;
  localparam int DAY     = HPD * 3600;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       load = 1'b0;
  logic [5:0] ld_sec = '0;
  logic [5:0] ld_min = '0;
  logic [4:0] ld_hour = '0;
  logic       mode_12h = 1'b0;
  logic       alarm_arm = 1'b0;
  logic [5:0] alarm_min = '0;
  logic [4:0] alarm_hour = '0;
  logic       alarm_hit;

  logic [5:0] out_sec;
  logic [5:0] out_min;
  logic [4:0] out_hour;
  logic       out_pm, sec_tick, day_wrap, load_err, running;

  rtc_hms_counter #(.CLK_DIV(CLK_DIV), .HOURS_PER_DAY(HPD)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .load       (load),
    .ld_sec     (ld_sec),
    .ld_min     (ld_min),
    .ld_hour    (ld_hour),
    .mode_12h   (mode_12h),
`ifdef RTC_ALARM_EN
    .alarm_arm  (alarm_arm),
    .alarm_min  (alarm_min),
    .alarm_hour (alarm_hour),
    .alarm_hit  (alarm_hit),
`endif
    .out_sec    (out_sec),
    .out_min    (out_min),
    .out_hour   (out_hour),
    .out_pm     (out_pm),
    .sec_tick   (sec_tick),
    .day_wrap   (day_wrap),
    .load_err   (load_err),
    .running    (running)
  );

`ifndef RTC_ALARM_EN
  assign alarm_hit = 1'b0;
`endif

  always #5 clk = ~clk;

  // reference model state
  int t   = 0;   // seconds since midnight
  int pre = 0;   // prescaler phase
  bit run = 0;
  bit exp_tick, exp_wrap, exp_err, exp_alarm;

  int vectors   = 0;
  int miscompares = 0;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic check_all();
    int h, disp;
    h    = t / 3600;
    disp = mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
    check("out_sec",  int'(out_sec),  t % 60);
    check("out_min",  int'(out_min),  (t / 60) % 60);
    check("out_hour", int'(out_hour), disp);
    check("out_pm",   int'(out_pm),   int'(mode_12h && h >= 12));
    check("sec_tick", int'(sec_tick), int'(exp_tick));
    check("day_wrap", int'(day_wrap), int'(exp_wrap));
    check("load_err", int'(load_err), int'(exp_err));
    check("running",  int'(running),  int'(run));
`ifdef RTC_ALARM_EN
    check("alarm_hit", int'(alarm_hit), int'(exp_alarm));
`endif
  endtask

  // Advance model by one edge using the currently driven inputs, then compare.
  task automatic cycle();
    bit ok, tk;
    exp_tick = 0; exp_wrap = 0; exp_err = 0; exp_alarm = 0;
    if (reset) begin
      t = 0; pre = 0; run = 0;
    end else begin
      ok = load && ld_sec < 60 && ld_min < 60 && ld_hour < HPD;
      tk = run && pre == CLK_DIV - 1;
      if (ok) begin
        t   = ld_hour * 3600 + ld_min * 60 + ld_sec;
        pre = 0;
      end else begin
        exp_err = load;
        if (run) begin
          if (tk) begin
            pre = 0;
            t = t + 1;
            exp_tick = 1;
            if (t == DAY) begin t = 0; exp_wrap = 1; end
          end else begin
            pre = pre + 1;
          end
        end
      end
`ifdef RTC_ALARM_EN
      exp_alarm = alarm_arm && (ok || tk) && t / 3600 == alarm_hour
                  && (t / 60) % 60 == alarm_min && t % 60 == 0;
`endif
      run = start;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load = 1; ld_hour = 5'(h); ld_min = 6'(m); ld_sec = 6'(s);
    cycle();
    load = 0;
  endtask

  initial begin
    int hs[5]     = '{0, 11, 12, 13, 23};
    int disp12[5] = '{12, 11, 12, 1, 11};
    int pm12[5]   = '{0, 0, 1, 1, 1};
    int guard;

    // reset state
    repeat (2) cycle();
    reset = 0;
    mode_12h = 1; #1;
    check("reset_hour_12h", int'(out_hour), 12);
    mode_12h = 0; #1;
    check("reset_hour_24h", int'(out_hour), 0);

    // run from zero: running next edge, tick every CLK_DIV cycles
    start = 1;
    cycle();
    check("running_after_start", int'(running), 1);
    repeat (3 * CLK_DIV) cycle();
    check("sec_after_3s", int'(out_sec), 3);

    // day rollover
    do_load(23, 59, 58);
    repeat (2 * CLK_DIV) cycle();
    check("rolled_to_midnight", int'(out_hour) + int'(out_min) + int'(out_sec), 0);

    // stop mid-second, hold, resume
    cycle();
    start = 0;
    cycle();
    repeat (10) cycle();
    start = 1;
    repeat (2 * CLK_DIV) cycle();

    // out-of-range load while stopped: rejected, nothing moves
    start = 0;
    cycle();
    do_load(5, 60, 10);
    check("bad_load_err", int'(load_err), 1);
    repeat (3) cycle();

    // load on the exact tick cycle: load wins, no sec_tick
    start = 1;
    cycle();
    guard = 0;
    while (!(run && pre == CLK_DIV - 1) && guard < 4 * CLK_DIV) begin
      cycle();
      guard++;
    end
    check("tick_wait_bound", int'(guard < 4 * CLK_DIV), 1);
    do_load(10, 20, 30);
    check("load_over_tick_no_tick", int'(sec_tick), 0);
    check("load_over_tick_sec", int'(out_sec), 30);

    // 12-hour display mapping, combinational on mode_12h
    start = 0;
    cycle();
    for (int i = 0; i < 5; i++) begin
      do_load(hs[i], 0, 0);
      mode_12h = 1; #1;
      check("disp12_hour", int'(out_hour), disp12[i]);
      check("disp12_pm",   int'(out_pm),   pm12[i]);
      mode_12h = 0; #1;
      check("disp24_hour", int'(out_hour), hs[i]);
    end

`ifdef RTC_ALARM_EN
    // armed alarm at 07:30, then disarmed
    alarm_hour = 5'd7; alarm_min = 6'd30; alarm_arm = 1;
    do_load(7, 29, 59);
    start = 1;
    repeat (3 * CLK_DIV) cycle();
    alarm_arm = 0;
    do_load(7, 29, 59);
    repeat (3 * CLK_DIV) cycle();
`endif

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      start    = ($urandom_range(0, 9) != 0);
      mode_12h = 1'($urandom);
      reset    = ($urandom_range(0, 199) == 0);
      load     = ($urandom_range(0, 11) == 0);
      ld_sec   = 6'($urandom_range(50, 63));
      ld_min   = ($urandom_range(0, 1) != 0) ? 6'd59 : 6'($urandom_range(0, 63));
      ld_hour  = ($urandom_range(0, 1) != 0) ? 5'd23 : 5'($urandom_range(0, 31));
`ifdef RTC_ALARM_EN
      alarm_arm  = 1;
      alarm_hour = ld_hour;
      alarm_min  = 6'(ld_min + 6'd1);
`endif
      cycle();
    end
    reset = 0;
    load  = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
